// File: rtl/vga_pkg.sv
// Shared frame-buffer constants and the slot tag used by the VRAM access arbiter.
package vga_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 16;
  localparam int H_ACTIVE    = 320;
  localparam int V_ACTIVE    = 240;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RD   = 2'd1,
    SLOT_WR   = 2'd2
  } slot_e;

endpackage

// File: rtl/vram_rd_tracker.sv
// Tracks the single outstanding BRAM read so the return data is captured exactly
// RD_LAT cycles after the read appears on the memory pins.
module vram_rd_tracker #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_issue_i,
  output logic rd_ret_o
);

  logic [RD_LAT-1:0] vld_q;

  // Flushed by reset so a read in flight is silently dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_issue_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign rd_ret_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/vram_access_arbiter.sv
// Time-slot arbiter for the single-port frame buffer: pclk cycles serve display
// reads, the remaining cycles serve the pixel writer through valid/ready.
module vram_access_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int RD_LAT  = 1,
  parameter int STALL_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pclk,
  input  logic              disp_de,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_enable,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              clr_stats,
  output logic [STALL_W-1:0] stall_cnt,
  output logic              pclk_err
);

  slot_e               slot_d, slot_q;
  logic                rd_req, wr_xfer;
  logic                mem_en_d, mem_en_q, mem_we_d, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0]   disp_data_q;
  logic                disp_valid_q;
  logic [STALL_W-1:0]  stall_d, stall_q;
  logic                pclk_q, pclk_err_d, pclk_err_q;
  logic                rd_ret;

  // The read slot owns the pclk cycle outright, so the writer is never offered it.
  assign wr_ready = wr_enable & ~pclk & reset_n;
  assign wr_xfer  = wr_valid & wr_ready;
  assign rd_req   = pclk & disp_de;

  always_comb begin
    slot_d      = SLOT_IDLE;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_req) begin
      slot_d     = SLOT_RD;
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr;
    end else if (wr_xfer) begin
      slot_d      = SLOT_WR;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (wr_valid && !wr_ready && !(&stall_q)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign pclk_err_d = clr_stats ? 1'b0 : (pclk_err_q | (pclk & pclk_q));

  vram_rd_tracker #(
    .RD_LAT(RD_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_issue_i(slot_q == SLOT_RD),
    .rd_ret_o  (rd_ret)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= SLOT_IDLE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      stall_q      <= '0;
      pclk_q       <= 1'b0;
      pclk_err_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_valid_q <= rd_ret;
      if (rd_ret) begin
        disp_data_q <= mem_rdata;
      end
      stall_q      <= stall_d;
      pclk_q       <= pclk;
      pclk_err_q   <= pclk_err_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign stall_cnt  = stall_q;
  assign pclk_err   = pclk_err_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Bench for vram_access_arbiter: BRAM behavioural memory, event-queue reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_vram_access_arbiter;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 16;
  localparam int RD_LAT  = 1;
  localparam int STALL_W = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               pclk = 1'b0;
  logic               disp_de = 1'b0;
  logic [ADDR_W-1:0]  disp_addr = '0;
  logic [DATA_W-1:0]  disp_data;
  logic               disp_valid;
  logic               wr_enable = 1'b0;
  logic               wr_valid = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic [DATA_W-1:0]  wr_data = '0;
  logic               wr_ready;
  logic               mem_en, mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata = '0;
  logic               clr_stats = 1'b0;
  logic [STALL_W-1:0] stall_cnt;
  logic               pclk_err;

  vram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pclk(pclk), .disp_de(disp_de),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_enable(wr_enable), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt), .pclk_err(pclk_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Single-port BRAM with one cycle of read latency.
  logic [DATA_W-1:0] bram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // Reference model: ideal memory plus a queue of pending display returns.
  typedef struct {
    int               due;
    logic [DATA_W-1:0] d;
  } ret_t;
  ret_t              rq[$];
  logic [DATA_W-1:0] mm [0:DEPTH-1];
  int                cyc = 0;
  logic              e_en = 0, e_we = 0, e_dv = 0, e_err = 0, prev_p = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_wd = '0, e_dd = '0;
  logic [STALL_W-1:0] e_stall = '0;

  initial begin : model
    logic rd, xf;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        e_en = 0; e_we = 0; e_dv = 0; e_err = 0; prev_p = 0;
        e_addr = '0; e_wd = '0; e_dd = '0; e_stall = '0;
        rq.delete();
      end else begin
        cyc++;
        rd = pclk & disp_de;
        xf = wr_valid & wr_enable & ~pclk;
        e_en = rd | xf;
        e_we = xf;
        if (rd) begin
          e_addr = disp_addr;
          rq.push_back('{cyc + RD_LAT + 1, mm[disp_addr]});
        end else if (xf) begin
          e_addr = wr_addr;
          e_wd   = wr_data;
          mm[wr_addr] = wr_data;
        end
        e_dv = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          e_dv = 1;
          e_dd = rq[0].d;
          void'(rq.pop_front());
        end
        if (clr_stats) e_stall = '0;
        else if (wr_valid && !(wr_enable && !pclk) && e_stall != '1) e_stall = e_stall + 1'b1;
        if (clr_stats) e_err = 0;
        else if (pclk && prev_p) e_err = 1;
        prev_p = pclk;
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_ready",   32'(wr_ready),   32'(wr_enable & ~pclk & reset_n));
    chk("mem_en",     32'(mem_en),     32'(e_en));
    chk("mem_we",     32'(mem_we),     32'(e_we));
    chk("mem_addr",   32'(mem_addr),   32'(e_addr));
    chk("mem_wdata",  32'(mem_wdata),  32'(e_wd));
    chk("disp_valid", 32'(disp_valid), 32'(e_dv));
    chk("disp_data",  32'(disp_data),  32'(e_dd));
    chk("stall_cnt",  32'(stall_cnt),  32'(e_stall));
    chk("pclk_err",   32'(pclk_err),   32'(e_err));
  end

  // Stimulus: one call drives one clk cycle and follows the writer handshake.
  logic              wr_auto = 0;
  logic [ADDR_W-1:0] wr_stop = '0;
  int                n_acc = 0;

  task automatic step(input logic p);
    logic acc;
    pclk = p;
    #1 acc = wr_valid & wr_ready;
    @(posedge clk);
    #2;
    if (acc) n_acc++;
    if (acc && wr_auto) begin
      wr_addr = wr_addr + 1'b1;
      wr_data = wr_data + 1'b1;
      if (wr_addr == wr_stop) wr_valid = 0;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [STALL_W-1:0] s0;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = dflt(ADDR_W'(i));
      mm[i]   = dflt(ADDR_W'(i));
    end
    bram[17'h00010] = 16'hF800;
    mm[17'h00010]   = 16'hF800;
    wr_enable = 1;
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_en",   32'(mem_en), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_stall",    32'(stall_cnt), 0);
    chk("rst_dvalid",   32'(disp_valid), 0);
    reset_n = 1;
    step(0); step(0);

    // Display read returning 0xF800.
    disp_de = 1; disp_addr = 17'h00010;
    step(1);
    chk("t1_en",   32'(mem_en), 1);
    chk("t1_we",   32'(mem_we), 0);
    chk("t1_addr", 32'(mem_addr), 32'h10);
    step(0); step(0);
    chk("t1_dvalid", 32'(disp_valid), 1);
    chk("t1_ddata",  32'(disp_data), 32'hF800);
    step(0);
    chk("t1_dvalid_pulse", 32'(disp_valid), 0);

    // Continuous writer: three accepts per pclk period.
    wr_valid = 1; wr_addr = 17'h12C00; wr_data = 16'h1000;
    wr_auto = 1; wr_stop = 17'h12C08; n_acc = 0; s0 = stall_cnt;
    for (int i = 0; i < 12; i++) begin
      step(i % 4 == 0);
      if (i == 7) begin
        chk("t2_acc_2per",   32'(n_acc), 6);
        chk("t2_stall_2per", 32'(stall_cnt - s0), 2);
      end
    end
    chk("t2_acc_total",   32'(n_acc), 8);
    chk("t2_stall_total", 32'(stall_cnt - s0), 3);

    // Tick with disp_de low while the writer is busy.
    disp_de = 0; wr_valid = 1; wr_addr = 17'h00100; wr_data = 16'h2222; wr_stop = 17'h00103;
    step(1);
    chk("t3_no_read_en", 32'(mem_en), 0);
    step(0); step(0);
    chk("t3_no_dvalid", 32'(disp_valid), 0);
    step(0);
    disp_de = 1; disp_addr = 17'h12C03;
    step(1); step(0); step(0);
    chk("t3_readback", 32'(disp_data), 32'h1003);
    step(0);

    // Two consecutive pclk cycles, both served as reads.
    disp_addr = 17'h00020;
    step(1);
    chk("t4_addr1", 32'(mem_addr), 32'h20);
    disp_addr = 17'h00021;
    step(1);
    chk("t4_en2",   32'(mem_en), 1);
    chk("t4_we2",   32'(mem_we), 0);
    chk("t4_addr2", 32'(mem_addr), 32'h21);
    chk("t4_err",   32'(pclk_err), 1);
    disp_de = 0;
    repeat (4) step(0);
    chk("t4_err_sticky", 32'(pclk_err), 1);
    clr_stats = 1;
    step(0);
    clr_stats = 0;
    chk("t4_err_clr",   32'(pclk_err), 0);
    chk("t4_stall_clr", 32'(stall_cnt), 0);

    // Saturate the stall counter with the writer frozen.
    wr_auto = 0; wr_enable = 0; wr_valid = 1; wr_addr = 17'h00300;
    for (int i = 0; i < 65540; i++) step(i % 4 == 0);
    chk("t5_sat", 32'(stall_cnt), 32'hFFFF);
    clr_stats = 1;
    step(0);
    clr_stats = 0;
    chk("t5_clr_wins", 32'(stall_cnt), 0);
    step(0);
    chk("t5_restart", 32'(stall_cnt), 1);
    wr_valid = 0; wr_enable = 1;

    // Reset one cycle after a read issue.
    disp_de = 1; disp_addr = 17'h00010;
    step(1);
    chk("t6_issue", 32'(mem_en), 1);
    #1 reset_n = 0;
    #1;
    chk("t6_async_en",    32'(mem_en), 0);
    chk("t6_async_addr",  32'(mem_addr), 0);
    chk("t6_async_ready", 32'(wr_ready), 0);
    chk("t6_async_stall", 32'(stall_cnt), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t6_no_dvalid", 32'(disp_valid), 0);
    reset_n = 1; disp_de = 0;
    step(0);
    wr_valid = 1; wr_addr = 17'h00055; wr_data = 16'hBEEF;
    step(0);
    wr_valid = 0;
    chk("t6_wr_en",    32'(mem_en), 1);
    chk("t6_wr_we",    32'(mem_we), 1);
    chk("t6_wr_addr",  32'(mem_addr), 32'h55);
    chk("t6_wr_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("t6_no_dvalid_after", 32'(disp_valid), 0);
    step(0); step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
